// File: rtl/phy_rx_sync_ctrl_pkg.sv
// Shared PHY lane definitions: sync FSM encoding plus the comma and TX
// serializer byte patterns.
package phy_rx_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } sync_state_t;

  localparam logic [7:0] COMMA_BYTE        = 8'hBC;
  localparam logic [7:0] TX_IDLE_PATTERN   = 8'hBC;
  localparam logic [7:0] TX_ACTIVE_PATTERN = 8'h7C;

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// Lane-side signal bundle of the receive sync controller; master drives the
// serial stream and enable, slave is the controller.
interface phy_rx_sync_ctrl_if;

  logic       enable;
  logic       in_serial;
  logic       active;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] sync_state;

  modport master (
    output enable, in_serial,
    input  active, data_out, valid_out, sync_state
  );

  modport slave (
    input  enable, in_serial,
    output active, data_out, valid_out, sync_state
  );

endinterface

// File: rtl/phy_rx_sync_ctrl_comma_detect.sv
// Serial-to-parallel shift register with a comma compare on its contents.
module phy_rx_sync_ctrl_comma_detect
  import phy_rx_sync_ctrl_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_BYTE
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] sr,
  output logic       is_comma
);

  logic [7:0] sr_reg;

  // MSB arrives first, so new bits enter at the LSB end.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr_reg <= 8'h00;
    end else begin
      sr_reg <= {sr_reg[6:0], in_serial};
    end
  end

  assign sr       = sr_reg;
  assign is_comma = (sr_reg == COMMA);

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive link sync controller: hunts for the comma, locks byte alignment
// after SYNC_COUNT aligned commas and then delivers aligned data bytes.
module phy_rx_sync_ctrl
  import phy_rx_sync_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COMMA      = COMMA_BYTE
) (
  input  logic              clk_32f,
  input  logic              reset,
  phy_rx_sync_ctrl_if.slave lane
);

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  sync_state_t state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  bc_cnt_reg, bc_cnt_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        active_reg;
  logic [7:0]  sr;
  logic        is_comma;
  logic        boundary;
  logic [3:0]  bc_inc;

  phy_rx_sync_ctrl_comma_detect #(
    .COMMA(COMMA)
  ) u_comma_detect (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .in_serial(lane.in_serial),
    .sr       (sr),
    .is_comma (is_comma)
  );

  assign boundary = (bit_cnt_reg == 3'd7);
  assign bc_inc   = bc_cnt_reg + 4'd1;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bc_cnt_next  = bc_cnt_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    // Dropping enable overrides any boundary decision in the same cycle.
    if (!lane.enable) begin
      state_next   = HUNT;
      bit_cnt_next = 3'd0;
      bc_cnt_next  = 4'd0;
      valid_next   = 1'b0;
    end else begin
      case (state_reg)
        HUNT: begin
          bit_cnt_next = 3'd0;
          if (is_comma) begin
            bc_cnt_next = 4'd1;
            state_next  = (SYNC_TARGET == 4'd1) ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (boundary) begin
            if (!is_comma) begin
              state_next   = HUNT;
              bit_cnt_next = 3'd0;
              bc_cnt_next  = 4'd0;
            end else if (bc_inc >= SYNC_TARGET) begin
              bc_cnt_next = SYNC_TARGET;
              state_next  = ACTIVE;
            end else begin
              bc_cnt_next = bc_inc;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              valid_next = 1'b0;
            end else begin
              data_next  = sr;
              valid_next = 1'b1;
            end
          end
        end
        default: begin
          state_next   = HUNT;
          bit_cnt_next = 3'd0;
          bc_cnt_next  = 4'd0;
          valid_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_reg   <= HUNT;
      bit_cnt_reg <= 3'd0;
      bc_cnt_reg  <= 4'd0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bc_cnt_reg  <= bc_cnt_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      active_reg  <= (state_next == ACTIVE);
    end
  end

  assign lane.active     = active_reg;
  assign lane.data_out   = data_reg;
  assign lane.valid_out  = valid_reg;
  assign lane.sync_state = state_reg;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: per-byte vector table plus edge-exact
// checks of lock latency, enable drop and asynchronous reset.
module tb_phy_rx_sync_ctrl;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  phy_rx_sync_ctrl_if bus ();

  phy_rx_sync_ctrl #(
    .SYNC_COUNT(4),
    .COMMA     (8'hBC)
  ) dut (
    .clk_32f(clk_32f),
    .reset  (reset),
    .lane   (bus)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         seg;
    bit         rst;
    logic [7:0] tx;
    logic [1:0] st;
    logic       act;
    logic       vld;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  int drop_a = -1;
  int drop_b = -1;

  logic [1:0] hist_st  [0:511];
  logic       hist_act [0:511];
  logic       hist_vld [0:511];
  logic [7:0] hist_dat [0:511];

  function automatic vec_t mk(input int seg, input bit rst, input logic [7:0] tx,
                              input logic [1:0] st, input logic act, input logic vld,
                              input logic [7:0] dat);
    vec_t v;
    v.seg = seg; v.rst = rst; v.tx = tx; v.st = st; v.act = act; v.vld = vld; v.dat = dat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Drives one bit for the next rising edge and records the outputs after it.
  task automatic tick(input logic b);
    bus.in_serial = b;
    bus.enable    = !((edge_n + 1 == drop_a) || (edge_n + 1 == drop_b));
    @(posedge clk_32f);
    edge_n++;
    #2;
    if (edge_n < 512) begin
      hist_st[edge_n]  = bus.sync_state;
      hist_act[edge_n] = bus.active;
      hist_vld[edge_n] = bus.valid_out;
      hist_dat[edge_n] = bus.data_out;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i]);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.in_serial = 1'b0;
    repeat (2) @(posedge clk_32f);
    #2;
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'h00);
    check("rst_state", 32'(bus.sync_state), 32'd0);
    reset  = 1'b0;
    edge_n = 0;
    for (int e = 0; e < 512; e++) begin
      hist_st[e] = 2'd0; hist_act[e] = 1'b0; hist_vld[e] = 1'b0; hist_dat[e] = 8'h00;
    end
  endtask

  function automatic int first_state(input int from, input logic [1:0] st);
    for (int e = from; e <= edge_n && e < 512; e++) if (hist_st[e] == st) return e;
    return -1;
  endfunction

  function automatic int first_active(input int from);
    for (int e = from; e <= edge_n && e < 512; e++) if (hist_act[e]) return e;
    return -1;
  endfunction

  function automatic int count_vd(input int lo, input int hi, input logic vld, input logic [7:0] dat);
    int n = 0;
    for (int e = lo; e <= hi; e++) if (hist_vld[e] == vld && hist_dat[e] == dat) n++;
    return n;
  endfunction

  function automatic logic [31:0] snap(input int e);
    return 32'({hist_st[e], hist_act[e], hist_vld[e], hist_dat[e]});
  endfunction

  // Each table byte is checked right after its last bit, so the outputs show
  // decisions up to the previous byte boundary.
  task automatic run_seg(input int seg);
    int j = 0;
    foreach (vecs[i]) begin
      if (vecs[i].seg == seg) begin
        if (vecs[i].rst) begin
          do_reset();
          repeat (3) tick(1'b0);
          j = 0;
        end
        send_byte(vecs[i].tx);
        $display("seg %0d byte %0d tx=%h edge=%0d state=%0d active=%b valid=%b data=%h",
                 seg, j, vecs[i].tx, edge_n, bus.sync_state, bus.active, bus.valid_out, bus.data_out);
        check($sformatf("s%0d_b%0d_state", seg, j), 32'(bus.sync_state), 32'(vecs[i].st));
        check($sformatf("s%0d_b%0d_active", seg, j), 32'(bus.active), 32'(vecs[i].act));
        check($sformatf("s%0d_b%0d_valid", seg, j), 32'(bus.valid_out), 32'(vecs[i].vld));
        check($sformatf("s%0d_b%0d_data", seg, j), 32'(bus.data_out), 32'(vecs[i].dat));
        j++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable    = 1'b1;
    bus.in_serial = 1'b0;

    // Lock on idle, data after lock, enable drop and relock.
    vecs.push_back(mk(0, 1, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h7C, 2'd2, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd2, 1, 1, 8'h7C));
    vecs.push_back(mk(0, 0, 8'h55, 2'd2, 1, 0, 8'h7C));
    vecs.push_back(mk(0, 0, 8'hA5, 2'd2, 1, 1, 8'h55));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd0, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 8'hBC, 2'd1, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 8'h33, 2'd2, 1, 0, 8'hA5));
    // Broken alignment.
    vecs.push_back(mk(1, 1, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h3C, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd2, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'hBC, 2'd2, 1, 0, 8'h00));
    // False comma across 0x5E,0x00.
    vecs.push_back(mk(2, 1, 8'h5E, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'h00, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd2, 1, 0, 8'h00));
    vecs.push_back(mk(2, 0, 8'hBC, 2'd2, 1, 0, 8'h00));
    // Lock with data in flight, ahead of the asynchronous reset.
    vecs.push_back(mk(3, 1, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(3, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(3, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(3, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(3, 0, 8'h96, 2'd2, 1, 0, 8'h00));
    vecs.push_back(mk(3, 0, 8'h5A, 2'd2, 1, 1, 8'h96));
    // Relock after reset release.
    vecs.push_back(mk(4, 1, 8'hBC, 2'd0, 0, 0, 8'h00));
    vecs.push_back(mk(4, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(4, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(4, 0, 8'hBC, 2'd1, 0, 0, 8'h00));
    vecs.push_back(mk(4, 0, 8'hBC, 2'd2, 1, 0, 8'h00));

    // Segment 0: enable low for edge 70 (mid-byte) and edge 108 (boundary).
    drop_a = 70; drop_b = 108;
    run_seg(0);
    send_byte(8'hBC);
    check("a_align_edge", 32'(first_state(1, 2'd1)), 32'd12);
    check("a_active_edge", 32'(first_active(1)), 32'd36);
    check("a_lock_latency", 32'(first_active(1) - first_state(1, 2'd1)), 32'd24);
    check("a_no_early_valid", 32'(count_vd(1, 43, 1'b1, 8'h00)), 32'd0);
    check("a_7c_8cycles", 32'(count_vd(44, 51, 1'b1, 8'h7C)), 32'd8);
    check("a_idle_8cycles", 32'(count_vd(52, 59, 1'b0, 8'h7C)), 32'd8);
    check("a_55_8cycles", 32'(count_vd(60, 67, 1'b1, 8'h55)), 32'd8);
    check("d_before_drop", snap(69), 32'({2'd2, 1'b1, 1'b1, 8'hA5}));
    check("d_after_drop", snap(70), 32'({2'd0, 1'b0, 1'b0, 8'hA5}));
    check("d_relock_align", 32'(first_state(71, 2'd1)), 32'd76);
    check("d_relock_active", 32'(first_active(71)), 32'd100);
    check("d_pre_boundary", snap(107), 32'({2'd2, 1'b1, 1'b0, 8'hA5}));
    check("d_drop_at_boundary", snap(108), 32'({2'd0, 1'b0, 1'b0, 8'hA5}));
    drop_a = -1; drop_b = -1;

    run_seg(1);
    check("b_align_before_3c", 32'(hist_st[27]), 32'd1);
    check("b_hunt_at_3c", 32'(hist_st[28]), 32'd0);
    check("b_no_early_active", 32'(first_active(1)), 32'd60);
    check("b_realign_edge", 32'(first_state(29, 2'd1)), 32'd36);
    check("b_lock_latency", 32'(first_active(1) - first_state(29, 2'd1)), 32'd24);

    run_seg(2);
    check("c_hunt_before_false", 32'(hist_st[12]), 32'd0);
    check("c_false_align", 32'(hist_st[13]), 32'd1);
    check("c_align_until_boundary", 32'(hist_st[20]), 32'd1);
    check("c_back_to_hunt", 32'(hist_st[21]), 32'd0);
    check("c_real_align", 32'(first_state(22, 2'd1)), 32'd28);
    check("c_active_edge", 32'(first_active(1)), 32'd52);

    run_seg(3);
    tick(1'b1); tick(1'b0); tick(1'b1);
    check("e_before_reset", 32'({bus.sync_state, bus.active, bus.valid_out, bus.data_out}),
          32'({2'd2, 1'b1, 1'b1, 8'h5A}));
    #1;
    reset = 1'b1;
    #1;
    $display("async reset at edge %0d: state=%0d active=%b valid=%b data=%h",
             edge_n, bus.sync_state, bus.active, bus.valid_out, bus.data_out);
    check("e_async_active", 32'(bus.active), 32'd0);
    check("e_async_valid", 32'(bus.valid_out), 32'd0);
    check("e_async_data", 32'(bus.data_out), 32'h00);
    check("e_async_state", 32'(bus.sync_state), 32'd0);

    run_seg(4);
    check("e_relock_align", 32'(first_state(1, 2'd1)), 32'd12);
    check("e_relock_active", 32'(first_active(1)), 32'd36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
